// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage PC sequencer with BTB metadata, mispredict recovery and counters
module fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int              BUBBLES  = 1,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_req,
    input  logic             btb_hit_f,
    input  logic [XLEN-1:0]  btb_target_f,
    input  logic             br_valid_e,
    input  logic             br_taken_e,
    input  logic [XLEN-1:0]  br_target_e,
    input  logic [XLEN-1:0]  pc_e,
    output logic [XLEN-1:0]  pc_f,
    output logic             fetch_valid,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             btb_upd,
    output logic             btb_upd_insert,
    output logic [XLEN-1:0]  btb_upd_pc,
    output logic [XLEN-1:0]  btb_upd_target,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    typedef struct packed {
        logic            valid;
        logic            pred_taken;
        logic [XLEN-1:0] pred_target;
    } meta_t;

    localparam int              BUB_M1     = (BUBBLES > 0) ? BUBBLES - 1 : 0;
    localparam logic [2:0]      BUB_LAST   = BUB_M1[2:0];
    localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(4);

    state_t           state_q, state_d;
    logic [2:0]       bub_q, bub_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    meta_t            meta_d_q, meta_d_d;
    meta_t            meta_e_q, meta_e_d;
    logic             upd_q, upd_d;
    logic             ins_q, ins_d;
    logic [XLEN-1:0]  upc_q, upc_d;
    logic [XLEN-1:0]  utgt_q, utgt_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;

    logic resolve;
    logic mispredict;
    logic running;
    logic hold;

    // A resolution only counts against a real, predicted instruction in E
    assign resolve    = br_valid_e & meta_e_q.valid;
    assign mispredict = resolve &
                        ((br_taken_e != meta_e_q.pred_taken) |
                         (br_taken_e & (br_target_e != meta_e_q.pred_target)));
    assign running    = (state_q == ST_RUN);
    assign hold       = running & stall_req & ~mispredict;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            bub_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        bub_d   = bub_q;
        if (mispredict) begin
            if (BUBBLES > 0) begin
                state_d = ST_RECOVER;
                bub_d   = BUB_LAST;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_BOOT:    state_d = ST_RUN;
                ST_RUN:     state_d = ST_RUN;
                ST_RECOVER: begin
                    if (bub_q == 3'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        bub_d = bub_q - 3'd1;
                    end
                end
                default:    state_d = ST_BOOT;
            endcase
        end
    end

    // Output logic
    always_comb begin
        fetch_valid = running;
        stall_f     = hold;
        stall_d     = hold;
        flush_d     = mispredict;
        flush_e     = mispredict | hold;
    end

    // PC and prediction metadata
    always_comb begin
        pc_d     = pc_q;
        meta_d_d = meta_d_q;
        meta_e_d = meta_e_q;
        if (mispredict) begin
            pc_d     = br_taken_e ? br_target_e : pc_e + INSN_BYTES;
            meta_d_d = '0;
            meta_e_d = '0;
        end else if (!running) begin
            meta_d_d = '0;
            meta_e_d = meta_d_q;
        end else if (stall_req) begin
            meta_e_d = '0;
        end else begin
            meta_d_d.valid       = 1'b1;
            meta_d_d.pred_taken  = btb_hit_f;
            meta_d_d.pred_target = btb_target_f;
            meta_e_d             = meta_d_q;
            pc_d                 = btb_hit_f ? btb_target_f : pc_q + INSN_BYTES;
        end
    end

    // Every mispredict maps to exactly one BTB action: taken inserts, not-taken removes
    always_comb begin
        upd_d  = mispredict;
        ins_d  = ins_q;
        upc_d  = upc_q;
        utgt_d = utgt_q;
        if (mispredict) begin
            ins_d  = br_taken_e;
            upc_d  = pc_e;
            utgt_d = br_target_e;
        end
        bcnt_d = (resolve && (bcnt_q != {CNT_W{1'b1}})) ? bcnt_q + 1'b1 : bcnt_q;
        mcnt_d = (mispredict && (mcnt_q != {CNT_W{1'b1}})) ? mcnt_q + 1'b1 : mcnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            meta_d_q <= '0;
            meta_e_q <= '0;
            upd_q    <= 1'b0;
            ins_q    <= 1'b0;
            upc_q    <= '0;
            utgt_q   <= '0;
            bcnt_q   <= '0;
            mcnt_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            meta_d_q <= meta_d_d;
            meta_e_q <= meta_e_d;
            upd_q    <= upd_d;
            ins_q    <= ins_d;
            upc_q    <= upc_d;
            utgt_q   <= utgt_d;
            bcnt_q   <= bcnt_d;
            mcnt_q   <= mcnt_d;
        end
    end

    assign pc_f           = pc_q;
    assign btb_upd        = upd_q;
    assign btb_upd_insert = ins_q;
    assign btb_upd_pc     = upc_q;
    assign btb_upd_target = utgt_q;
    assign branch_cnt     = bcnt_q;
    assign mispred_cnt    = mcnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

    localparam int          XLEN   = 32;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] RST_PC = 32'h100;

    typedef enum int {S_PC, S_FV, S_SF, S_SD, S_FD, S_FE, S_UPD, S_INS, S_UPC, S_UTGT, S_BC, S_MC} sig_e;
    typedef struct {
        string       tag;
        sig_e        sig;
        logic [31:0] val;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             stall_req;
    logic             btb_hit_f;
    logic [XLEN-1:0]  btb_target_f;
    logic             br_valid_e;
    logic             br_taken_e;
    logic [XLEN-1:0]  br_target_e;
    logic [XLEN-1:0]  pc_e;
    logic [XLEN-1:0]  pc_f;
    logic             fetch_valid;
    logic             stall_f;
    logic             stall_d;
    logic             flush_d;
    logic             flush_e;
    logic             btb_upd;
    logic             btb_upd_insert;
    logic [XLEN-1:0]  btb_upd_pc;
    logic [XLEN-1:0]  btb_upd_target;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    fetch_ctrl #(
        .XLEN     (XLEN),
        .RESET_PC (RST_PC),
        .BUBBLES  (1),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_req      (stall_req),
        .btb_hit_f      (btb_hit_f),
        .btb_target_f   (btb_target_f),
        .br_valid_e     (br_valid_e),
        .br_taken_e     (br_taken_e),
        .br_target_e    (br_target_e),
        .pc_e           (pc_e),
        .pc_f           (pc_f),
        .fetch_valid    (fetch_valid),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .btb_upd        (btb_upd),
        .btb_upd_insert (btb_upd_insert),
        .btb_upd_pc     (btb_upd_pc),
        .btb_upd_target (btb_upd_target),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] obs(input sig_e s);
        case (s)
            S_PC:    return pc_f;
            S_FV:    return 32'(fetch_valid);
            S_SF:    return 32'(stall_f);
            S_SD:    return 32'(stall_d);
            S_FD:    return 32'(flush_d);
            S_FE:    return 32'(flush_e);
            S_UPD:   return 32'(btb_upd);
            S_INS:   return 32'(btb_upd_insert);
            S_UPC:   return btb_upd_pc;
            S_UTGT:  return btb_upd_target;
            S_BC:    return 32'(branch_cnt);
            default: return 32'(mispred_cnt);
        endcase
    endfunction

    task automatic push(input string tag, input sig_e s, input logic [31:0] v);
        exp_t x;
        x.tag = tag;
        x.sig = s;
        x.val = v;
        sb.push_back(x);
    endtask

    task automatic idle();
        stall_req    = 1'b0;
        btb_hit_f    = 1'b0;
        btb_target_f = '0;
        br_valid_e   = 1'b0;
        br_taken_e   = 1'b0;
        br_target_e  = '0;
        pc_e         = '0;
    endtask

    task automatic resolve(input logic taken, input logic [31:0] tgt, input logic [31:0] pce);
        br_valid_e  = 1'b1;
        br_taken_e  = taken;
        br_target_e = tgt;
        pc_e        = pce;
    endtask

    task automatic test_reset();
        push("rst_pc", S_PC, RST_PC);
        push("rst_fv", S_FV, 0);
        push("rst_stall_f", S_SF, 0);
        push("rst_flush_d", S_FD, 0);
        push("rst_flush_e", S_FE, 0);
        push("rst_upd", S_UPD, 0);
        push("rst_bc", S_BC, 0);
        push("rst_mc", S_MC, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs(e.sig) !== e.val) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", e.tag, obs(e.sig), e.val);
            end
        end
    endtask

    task automatic test_boot();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            idle();
            case (c)
                0: begin push("boot_pc0", S_PC, 32'h100); push("boot_fv0", S_FV, 0); end
                1: begin push("boot_pc1", S_PC, 32'h100); push("boot_fv1", S_FV, 1); end
                default: begin push("boot_pc2", S_PC, 32'h104); push("boot_fv2", S_FV, 1); end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (obs(e.sig) !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h", e.tag, obs(e.sig), e.val);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_predicted_hit();
        for (int c = 0; c < 4; c++) begin
            idle();
            case (c)
                0: begin btb_hit_f = 1'b1; btb_target_f = 32'h200; push("hit_pc", S_PC, 32'h108); end
                1: push("hit_redirect", S_PC, 32'h200);
                2: begin
                    resolve(1'b1, 32'h200, 32'h108);
                    push("hit_pc_seq", S_PC, 32'h204);
                    push("hit_no_flush_d", S_FD, 0);
                    push("hit_no_flush_e", S_FE, 0);
                end
                default: begin
                    push("hit_no_upd", S_UPD, 0);
                    push("hit_bc", S_BC, 1);
                    push("hit_mc", S_MC, 0);
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (obs(e.sig) !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h", e.tag, obs(e.sig), e.val);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_unpredicted_taken();
        for (int c = 0; c < 2; c++) begin
            idle();
            if (c == 0) begin
                resolve(1'b1, 32'h400, 32'h10C);
                push("unp_pc", S_PC, 32'h20C);
                push("unp_flush_d", S_FD, 1);
                push("unp_flush_e", S_FE, 1);
                push("unp_stall_f", S_SF, 0);
            end else begin
                push("unp_redirect", S_PC, 32'h400);
                push("unp_bubble", S_FV, 0);
                push("unp_upd", S_UPD, 1);
                push("unp_insert", S_INS, 1);
                push("unp_upd_pc", S_UPC, 32'h10C);
                push("unp_upd_tgt", S_UTGT, 32'h400);
                push("unp_mc", S_MC, 1);
                push("unp_bc", S_BC, 2);
            end
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (obs(e.sig) !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h", e.tag, obs(e.sig), e.val);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_pred_not_taken();
        for (int c = 0; c < 5; c++) begin
            idle();
            case (c)
                0: begin
                    btb_hit_f = 1'b1; btb_target_f = 32'h500;
                    push("pnt_recovered_pc", S_PC, 32'h400);
                    push("pnt_recovered_fv", S_FV, 1);
                    push("pnt_upd_single", S_UPD, 0);
                end
                1: push("pnt_pred_pc", S_PC, 32'h500);
                2: begin
                    resolve(1'b0, 32'h0, 32'h20);
                    push("pnt_pc", S_PC, 32'h504);
                    push("pnt_flush_d", S_FD, 1);
                    push("pnt_flush_e", S_FE, 1);
                end
                3: begin
                    btb_hit_f = 1'b1; btb_target_f = 32'h900;
                    push("pnt_fallthru", S_PC, 32'h24);
                    push("pnt_bubble", S_FV, 0);
                    push("pnt_upd", S_UPD, 1);
                    push("pnt_remove", S_INS, 0);
                    push("pnt_upd_pc", S_UPC, 32'h20);
                    push("pnt_mc", S_MC, 2);
                    push("pnt_bc", S_BC, 3);
                end
                default: begin
                    push("pnt_hit_ignored_in_recover", S_PC, 32'h24);
                    push("pnt_fv_back", S_FV, 1);
                    push("pnt_upd_clear", S_UPD, 0);
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (obs(e.sig) !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h", e.tag, obs(e.sig), e.val);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        for (int c = 0; c < 7; c++) begin
            idle();
            case (c)
                0: push("stl_pc28", S_PC, 32'h28);
                1: push("stl_pc2c", S_PC, 32'h2C);
                2, 3: begin
                    stall_req = 1'b1;
                    if (c == 3) resolve(1'b1, 32'h700, 32'h2C);
                    push("stl_pc_hold", S_PC, 32'h30);
                    push("stl_stall_f", S_SF, 1);
                    push("stl_stall_d", S_SD, 1);
                    push("stl_flush_e", S_FE, 1);
                    push("stl_no_flush_d", S_FD, 0);
                end
                4: begin
                    push("stl_release_pc", S_PC, 32'h30);
                    push("stl_release_sf", S_SF, 0);
                    push("stl_release_fe", S_FE, 0);
                end
                5: begin
                    stall_req = 1'b1;
                    resolve(1'b1, 32'h600, 32'h2C);
                    push("stl_ovr_pc", S_PC, 32'h34);
                    push("stl_ovr_stall_f", S_SF, 0);
                    push("stl_ovr_stall_d", S_SD, 0);
                    push("stl_ovr_flush_d", S_FD, 1);
                    push("stl_ovr_flush_e", S_FE, 1);
                end
                default: begin
                    stall_req = 1'b1;
                    push("stl_ovr_redirect", S_PC, 32'h600);
                    push("stl_ovr_bubble", S_FV, 0);
                    push("stl_recover_ignores", S_SF, 0);
                    push("stl_recover_fe", S_FE, 0);
                    push("stl_ovr_upd", S_UPD, 1);
                    push("stl_ovr_upd_pc", S_UPC, 32'h2C);
                    push("stl_ovr_upd_tgt", S_UTGT, 32'h600);
                    push("stl_bc", S_BC, 4);
                    push("stl_mc", S_MC, 3);
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (obs(e.sig) !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h", e.tag, obs(e.sig), e.val);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        for (int c = 0; c <= 80; c++) begin
            idle();
            if (c == 80) begin
                push("sat_mc", S_MC, 15);
                push("sat_bc", S_BC, 15);
            end else if ((c % 4) == 2) begin
                resolve(1'b1, 32'h800 + 32'(c) * 32'h10, 32'h40);
                push("sat_flush_d", S_FD, 1);
            end
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (obs(e.sig) !== e.val) begin
                    errors++;
                    $display("FAIL %s (cycle %0d): got %0h expected %0h", e.tag, c, obs(e.sig), e.val);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_recover();
        for (int c = 0; c < 4; c++) begin
            idle();
            case (c)
                0: ;
                1: begin resolve(1'b1, 32'hA00, 32'h44); push("rmr_flush_d", S_FD, 1); end
                2: begin
                    push("rmr_recover_pc", S_PC, 32'hA00);
                    push("rmr_recover_fv", S_FV, 0);
                    push("rmr_pending_upd", S_UPD, 1);
                end
                default: begin
                    rst = 1'b1;
                    #1;
                    push("rmr_pc", S_PC, RST_PC);
                    push("rmr_fv", S_FV, 0);
                    push("rmr_upd_dropped", S_UPD, 0);
                    push("rmr_bc", S_BC, 0);
                    push("rmr_mc", S_MC, 0);
                    push("rmr_flush_d", S_FD, 0);
                end
            endcase
            if (c != 3) @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (obs(e.sig) !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h", e.tag, obs(e.sig), e.val);
                end
            end
            if (c == 2) begin
                #1;
            end else begin
                @(posedge clk); #1;
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_boot();
        test_predicted_hit();
        test_unpredicted_taken();
        test_pred_not_taken();
        test_stall();
        test_saturation();
        test_reset_mid_recover();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
